// File: rtl/key_schedule_ctrl_pkg.sv
// Shared types and sizes for the AES-256 key schedule controller.
// The cipher-round controller imports the same package.
package key_schedule_ctrl_pkg;

  localparam int NUM_RK = 15;
  localparam int RK_W   = 128;
  localparam int KEY_W  = 256;
  localparam int MAX_R  = 7;
  localparam int R_W    = 5;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

endpackage

// File: rtl/round_key.sv
// One AES-256 key-expansion step: turns eight schedule words into the next eight.
// Word i sits at bits [32i+31:32i]; byte 0 of a word is its most significant byte.
module round_key
  import key_schedule_ctrl_pkg::*;
(
  input  logic [KEY_W-1:0] k,
  input  logic [R_W-1:0]   r,
  output logic [KEY_W-1:0] result
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // The S-box is computed as the GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    inv  = gf_mul(gf_mul(a240, a12), a2);
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [31:0] w [8];
  logic [31:0] n [8];
  logic [7:0]  rcon;
  logic [31:0] rot_w7;

  always_comb begin
    for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
  end

  // rcon is only meaningful for r = 1..7; other values are never applied.
  assign rcon   = 8'h01 << (r - 5'd1);
  assign rot_w7 = {w[7][23:0], w[7][31:24]};

  always_comb begin
    n[0] = w[0] ^ sub_word(rot_w7) ^ {rcon, 24'h000000};
    n[1] = w[1] ^ n[0];
    n[2] = w[2] ^ n[1];
    n[3] = w[3] ^ n[2];
    n[4] = w[4] ^ sub_word(n[3]);
    n[5] = w[5] ^ n[4];
    n[6] = w[6] ^ n[5];
    n[7] = w[7] ^ n[6];
  end

  assign result = {n[7], n[6], n[5], n[4], n[3], n[2], n[1], n[0]};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Accepts a 256-bit key, expands it into 15 round keys over 7 cycles and serves
// registered reads of the stored schedule.
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              key_v_i,
  input  logic [KEY_W-1:0]  key_i,
  output logic              key_ready_o,
  output logic              keys_valid_o,
  input  logic              rd_v_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_v_o,
  output logic [RK_W-1:0]   rd_data_o,
  input  logic              abort_i
);

  ks_state_e        state, state_nxt;
  logic [R_W-1:0]   r_q;
  logic [KEY_W-1:0] cur_key_q;
  logic [KEY_W-1:0] step;
  logic             keys_valid_q;
  logic             key_accept;
  logic             expand_en;

  logic             wr_en;
  logic             wr_hi_en;
  logic [2:0]       wr_pair;
  logic [RK_W-1:0]  wr_lo;
  logic [RK_W-1:0]  wr_hi;
  logic [RK_W-1:0]  rk_mem [NUM_RK];

  logic             rd_accept;
  logic             rd_v_q;
  logic [RK_W-1:0]  rd_data_q;

  round_key u_round_key (
    .k      (cur_key_q),
    .r      (r_q),
    .result (step)
  );

  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    key_accept = 1'b0;
    expand_en  = 1'b0;
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, READY: begin
          if (key_v_i) begin
            key_accept = 1'b1;
            state_nxt  = EXPAND;
          end
        end
        EXPAND: begin
          expand_en = 1'b1;
          if (r_q == R_W'(MAX_R)) state_nxt = READY;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign key_ready_o  = (state != EXPAND);
  assign keys_valid_o = keys_valid_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_q          <= '0;
      cur_key_q    <= '0;
      keys_valid_q <= 1'b0;
    end else if (abort_i) begin
      r_q          <= '0;
      cur_key_q    <= '0;
      keys_valid_q <= 1'b0;
    end else if (key_accept) begin
      r_q          <= R_W'(1);
      cur_key_q    <= key_i;
      keys_valid_q <= 1'b0;
    end else if (expand_en) begin
      r_q       <= r_q + R_W'(1);
      cur_key_q <= step;
      if (r_q == R_W'(MAX_R)) keys_valid_q <= 1'b1;
    end
  end

  // Acceptance writes rk0/rk1 from the key; each expansion step writes rk(2r)/rk(2r+1).
  assign wr_en    = key_accept | expand_en;
  assign wr_pair  = key_accept ? 3'd0 : r_q[2:0];
  assign wr_lo    = key_accept ? key_i[RK_W-1:0] : step[RK_W-1:0];
  assign wr_hi    = key_accept ? key_i[KEY_W-1:RK_W] : step[KEY_W-1:RK_W];
  assign wr_hi_en = key_accept | (expand_en && (r_q < R_W'(MAX_R)));

  // NOTE: the key store has no reset; its contents stay hidden until
  // keys_valid_o is set, so reset logic on 1920 flops would buy nothing.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      rk_mem[{wr_pair, 1'b0}] <= wr_lo;
      if (wr_hi_en) rk_mem[{wr_pair, 1'b1}] <= wr_hi;
    end
  end

  // Reads sample the array before this edge's write, so a read alongside a new
  // key returns the old schedule.
  assign rd_accept = rd_v_i & keys_valid_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_v_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_v_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= (rd_addr_i == ADDR_W'(NUM_RK)) ? '0 : rk_mem[rd_addr_i];
      end
    end
  end

  assign rd_v_o    = rd_v_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port key_v_i, input, 1 bit: a 256-bit cipher key is offered.
REQ-004 SHALL have port key_i, input, 256 bits: cipher key; word w[i] sits at bits [32i+31:32i].
REQ-005 SHALL have port key_ready_o, output, 1 bit: key accepted on the edge where key_v_i & key_ready_o.
REQ-006 SHALL have port keys_valid_o, output, 1 bit: all 15 round keys are stored and readable.
REQ-007 SHALL have port rd_v_i, input, 1 bit: round-key read request.
REQ-008 SHALL have port rd_addr_i, input, 4 bits: round-key index 0..14.
REQ-009 SHALL have port rd_v_o, output, 1 bit: rd_data_o is valid this cycle.
REQ-010 SHALL have port rd_data_o, output, 128 bits: the requested round key.
REQ-011 SHALL have port abort_i, input, 1 bit: synchronous abandon of the current schedule.

Function
REQ-012 SHALL implement an FSM with states IDLE, EXPAND and READY.
REQ-013 key_ready_o SHALL be 1 in IDLE and READY, and 0 in EXPAND.
REQ-014 On key acceptance the block SHALL:
- store rk0 = key_i[127:0] and rk1 = key_i[255:128];
- load the working register cur_key with key_i;
- set the round counter r to 1;
- enter EXPAND;
- clear keys_valid_o.
REQ-015 In EXPAND, each cycle SHALL apply one combinational expansion step to (cur_key, r) and store the result: rk(2r) = step[127:0]; rk(2r+1) = step[255:128] only if 2r+1 <= 14. The same edge SHALL set cur_key to step and increment r.
REQ-016 The expansion step SHALL use rcon = 1 << (r-1), with r held in 5 bits and valid for r = 1..7 only.
REQ-017 On the edge where r = 7 is processed, the FSM SHALL enter READY and set keys_valid_o. This edge is 7 cycles after acceptance, and rk15 is discarded.
REQ-018 A key accepted in READY SHALL restart the expansion exactly as from IDLE, and keys_valid_o SHALL drop on that edge.
REQ-019 abort_i SHALL return the FSM to IDLE and clear keys_valid_o, r and cur_key from any state. abort_i SHALL take priority over key acceptance in the same cycle.
REQ-020 A read SHALL be accepted only when rd_v_i & keys_valid_o. On the following cycle rd_v_o = 1 and rd_data_o = rk[rd_addr_i], giving 1-cycle latency.
REQ-021 Reads SHALL be back-to-back capable: one read per cycle at full throughput.
REQ-022 rd_addr_i = 15 SHALL return rd_data_o = 0 with rd_v_o = 1.
REQ-023 A read issued while keys_valid_o = 0 SHALL produce rd_v_o = 0 the next cycle, and rd_data_o SHALL hold its prior value.
REQ-024 A read in the same cycle as a new key acceptance in READY SHALL return the old schedule's key, because storage updates on that edge.
REQ-025 Round-key storage SHALL be written only in the acceptance and EXPAND cycles, and never by reads.

Reset
REQ-026 reset_i SHALL asynchronously force the following, independent of clk_i:
- FSM = IDLE, r = 0, cur_key = 0;
- key_ready_o = 1, keys_valid_o = 0;
- rd_v_o = 0, rd_data_o = 0.
REQ-027 Round-key storage SHALL need no reset. Its contents SHALL be unobservable until keys_valid_o = 1.
REQ-028 Reset asserted mid-EXPAND SHALL abandon the expansion. After release the block SHALL accept a fresh key normally.

Structure
REQ-029 A shared package SHALL hold the following, for reuse by the cipher-round controller:
- the FSM state enum;
- NUM_RK = 15, RK_W = 128, KEY_W = 256, MAX_R = 7.
REQ-030 The one combinational expansion step SHALL be a single instance of the existing sub-module round_key (k, r, result), with no duplicate S-box logic.
REQ-031 Storage SHALL be a 15 x 128-bit flop array with one write-pair port and one registered read port.

Verification
REQ-032 Accept key 256'h0 at cycle 0: key_ready_o = 0 on cycles 1-7, keys_valid_o = 1 from cycle 7, and rk0 = rk1 = 128'h0.
REQ-033 FIPS-197 AES-256 key 603deb10...0914dff4: all 15 round keys read back equal a golden model of round_key iterated r = 1..7.
REQ-034 Read rd_addr_i = 0..15 on consecutive cycles: rd_v_o on 16 consecutive cycles, addresses 0-14 return the model keys, and address 15 returns 0.
REQ-035 Assert abort_i at cycle 3 of EXPAND together with key_v_i: FSM = IDLE and keys_valid_o = 0; the next key restarts with latency 7.
REQ-036 Pulse reset_i asynchronously, between clock edges, mid-EXPAND: outputs take reset values immediately, and a subsequent key completes correctly.
REQ-037 New key in READY with a simultaneous read of address 14: the read returns the old rk14, and keys_valid_o falls on the same edge.
